// File: rtl/pwm_mixer_pkg.sv
// rtl/pwm_mixer_pkg.sv - shared types, widths and the voice scaling helper for pwm_mixer
package pwm_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam logic [3:0] VOL_MAX     = 4'd15;
  localparam int         PWM_BITS    = 9;
  localparam int         SAMPLE_BITS = 7;

  // 7x4 product keeps its top 7 bits, so a full-scale voice contributes at most 119
  function automatic logic [PWM_BITS-1:0] voice_term(input logic [SAMPLE_BITS-1:0] s,
                                                     input logic [3:0]             v);
    logic [SAMPLE_BITS+3:0] prod;
    prod = {4'b0000, s} * {{SAMPLE_BITS{1'b0}}, v};
    return {2'b00, prod[SAMPLE_BITS+3:4]};
  endfunction

endpackage

// File: rtl/pwm_mixer_voice_env.sv
// rtl/pwm_mixer_voice_env.sv - gated attack/sustain/release volume envelope for one voice
module voice_env
  import pwm_mixer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gate,
  input  logic       tick,
  output logic [3:0] vol,
  output logic       active
);

  env_state_t r_state;
  env_state_t w_state_nxt;
  logic [3:0] r_vol;
  logic [3:0] w_vol_nxt;
  logic       r_gate_q;
  logic       w_rise;
  logic       w_fall;

  assign w_rise = gate & ~r_gate_q;
  assign w_fall = ~gate & r_gate_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_vol    <= 4'd0;
      r_gate_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vol    <= w_vol_nxt;
      r_gate_q <= gate;
    end
  end

  // Gate edges win over a coincident tick: the state changes and the volume holds for that cycle
  always_comb begin
    w_state_nxt = r_state;
    w_vol_nxt   = r_vol;
    case (r_state)
      IDLE: begin
        if (w_rise) w_state_nxt = ATTACK;
      end
      ATTACK: begin
        if (w_fall) begin
          w_state_nxt = RELEASE;
        end else if (r_vol == VOL_MAX) begin
          w_state_nxt = SUSTAIN;
        end else if (tick) begin
          w_vol_nxt = r_vol + 4'd1;
          if (r_vol == VOL_MAX - 4'd1) w_state_nxt = SUSTAIN;
        end
      end
      SUSTAIN: begin
        w_vol_nxt = VOL_MAX;
        if (w_fall) w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (w_rise) begin
          w_state_nxt = ATTACK;
        end else if (r_vol == 4'd0) begin
          w_state_nxt = IDLE;
        end else if (tick) begin
          w_vol_nxt = r_vol - 4'd1;
          if (r_vol == 4'd1) w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_vol_nxt   = 4'd0;
      end
    endcase
  end

  assign vol    = r_vol;
  assign active = (r_state != IDLE);

endmodule

// File: rtl/pwm_mixer.sv
// rtl/pwm_mixer.sv - four-voice enveloped mixer with one shared multiplier driving a 9-bit PWM pin
module pwm_mixer
  import pwm_mixer_pkg::*;
#(
  parameter int ENV_TICK_BITS = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SAMPLE_BITS-1:0] sample1,
  input  logic [SAMPLE_BITS-1:0] sample2,
  input  logic [SAMPLE_BITS-1:0] sample3,
  input  logic [SAMPLE_BITS-1:0] sample4,
  input  logic [3:0]             gate,
  output logic                   pwm_out,
  output logic [PWM_BITS-1:0]    level,
  output logic [3:0]             env_active
);

  logic [ENV_TICK_BITS-1:0] r_tick_cnt;
  logic                     w_tick;
  logic [PWM_BITS-1:0]      r_cnt;
  logic [PWM_BITS-1:0]      r_acc;
  logic [PWM_BITS-1:0]      r_mix_next;
  logic [PWM_BITS-1:0]      r_level;
  logic                     r_pwm;
  logic [3:0][3:0]          w_vol;
  logic [3:0]               w_active;
  logic [SAMPLE_BITS-1:0]   w_sel_sample;
  logic [3:0]               w_sel_vol;
  logic [PWM_BITS-1:0]      w_term;

  assign w_tick = &r_tick_cnt;

  voice_env u_env0 (.clk(clk), .rst_n(rst_n), .gate(gate[0]), .tick(w_tick),
                    .vol(w_vol[0]), .active(w_active[0]));
  voice_env u_env1 (.clk(clk), .rst_n(rst_n), .gate(gate[1]), .tick(w_tick),
                    .vol(w_vol[1]), .active(w_active[1]));
  voice_env u_env2 (.clk(clk), .rst_n(rst_n), .gate(gate[2]), .tick(w_tick),
                    .vol(w_vol[2]), .active(w_active[2]));
  voice_env u_env3 (.clk(clk), .rst_n(rst_n), .gate(gate[3]), .tick(w_tick),
                    .vol(w_vol[3]), .active(w_active[3]));

  // The single multiplier visits voice 1..4 on cnt 0..3; cnt[1:0] selects the operands
  always_comb begin
    w_sel_sample = '0;
    w_sel_vol    = '0;
    case (r_cnt[1:0])
      2'd0: begin w_sel_sample = sample1; w_sel_vol = w_vol[0]; end
      2'd1: begin w_sel_sample = sample2; w_sel_vol = w_vol[1]; end
      2'd2: begin w_sel_sample = sample3; w_sel_vol = w_vol[2]; end
      default: begin w_sel_sample = sample4; w_sel_vol = w_vol[3]; end
    endcase
  end

  assign w_term = voice_term(w_sel_sample, w_sel_vol);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mix_next <= '0;
      r_level    <= '0;
      r_pwm      <= 1'b0;
    end else begin
      r_tick_cnt <= r_tick_cnt + {{(ENV_TICK_BITS-1){1'b0}}, 1'b1};
      r_cnt      <= r_cnt + 9'd1;
      if (r_cnt == 9'd0) begin
        r_acc <= w_term;
      end else if (r_cnt <= 9'd3) begin
        r_acc <= r_acc + w_term;
      end
      if (r_cnt == 9'd4) r_mix_next <= r_acc;
      // Duty only changes across the period boundary so no period sees two levels
      if (r_cnt == 9'd511) r_level <= r_mix_next;
      r_pwm <= (r_cnt < r_level);
    end
  end

  assign pwm_out    = r_pwm;
  assign level      = r_level;
  assign env_active = w_active;

endmodule
